// File: rtl/vga_plot_scheduler_if.sv
// Requester-side pixel bus for vga_plot_scheduler: three packed requesters plus per-requester ack.
interface vga_plot_scheduler_if;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_col;
  logic [2:0]  ack;

  modport master (output req, req_x, req_y, req_col, input ack);
  modport slave  (input req, req_x, req_y, req_col, output ack);
endinterface

// File: rtl/vga_plot_scheduler.sv
// Frame-buffer write-port scheduler: round-robin over three pixel requesters plus a full-screen clear engine.
// Optional build macro PLOT_SCHED_BORDER_EN: clear engine paints the screen edge in BORDER_COLOUR.
module vga_plot_scheduler #(
  parameter logic [7:0] X_MAX         = 8'd159,
  parameter logic [6:0] Y_MAX         = 7'd119,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] BORDER_COLOUR = 3'b111
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear_start,
  vga_plot_scheduler_if.slave   rq,
  output logic [7:0]            x,
  output logic [6:0]            y,
  output logic [2:0]            colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  clear_done,
  output logic                  state_dbg
);

  // Handshake: a requester raises req[i] with its fields stable and holds it until it sees
  // ack[i]=1 for one cycle; that ack means the pixel was taken, and the requester may change
  // data or drop req on the edge ending the ack cycle. ack[i] high masks req[i] for that cycle.

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [2:0]  ack_q, ack_d;
  logic [7:0]  x_d;
  logic [6:0]  y_d;
  logic [2:0]  colour_d;
  logic        plot_d, busy_d, done_d;

  logic [2:0]  elig;
  logic        gnt_valid;
  logic [1:0]  gnt_idx;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_col;
  logic        last_px, arb_en;
  logic [7:0]  clr_x;
  logic [6:0]  clr_y;
  logic [2:0]  clr_col;

  assign rq.ack    = ack_q;
  assign state_dbg = state_q;
  assign elig      = rq.req & ~ack_q;
  assign last_px   = (cx_q == X_MAX) && (cy_q == Y_MAX);
  assign arb_en    = ((state_q == S_IDLE) && !clear_start) || ((state_q == S_CLEAR) && last_px);

  // Search from ptr upward, modulo 3.
  always_comb begin
    logic [2:0] s;
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    s         = 3'd0;
    for (int k = 0; k < 3; k++) begin
      s = {1'b0, ptr_q} + 3'(k);
      if (s >= 3'd3) s = s - 3'd3;
      if (!gnt_valid && elig[s[1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = s[1:0];
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd1:    begin sel_x = rq.req_x[15:8];  sel_y = rq.req_y[13:7];  sel_col = rq.req_col[5:3]; end
      2'd2:    begin sel_x = rq.req_x[23:16]; sel_y = rq.req_y[20:14]; sel_col = rq.req_col[8:6]; end
      default: begin sel_x = rq.req_x[7:0];   sel_y = rq.req_y[6:0];   sel_col = rq.req_col[2:0]; end
    endcase
  end

  // Pixel the clear engine emits on the next edge: origin when starting, else raster successor.
  always_comb begin
    clr_x = 8'd0;
    clr_y = 7'd0;
    if (state_q == S_CLEAR) begin
      if (cx_q == X_MAX) begin
        clr_x = 8'd0;
        clr_y = (cy_q == Y_MAX) ? 7'd0 : cy_q + 7'd1;
      end else begin
        clr_x = cx_q + 8'd1;
        clr_y = cy_q;
      end
    end
  end

`ifdef PLOT_SCHED_BORDER_EN
  assign clr_col = ((clr_x == 8'd0) || (clr_x == X_MAX) || (clr_y == 7'd0) || (clr_y == Y_MAX))
                   ? BORDER_COLOUR : BG_COLOUR;
`else
  logic unused_border;
  assign unused_border = ^BORDER_COLOUR;
  assign clr_col       = BG_COLOUR;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear_start) state_d = S_CLEAR;
      S_CLEAR: if (last_px)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d    = 3'd0;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    ptr_d    = ptr_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    if (((state_q == S_IDLE) && clear_start) || ((state_q == S_CLEAR) && !last_px)) begin
      busy_d   = 1'b1;
      plot_d   = 1'b1;
      x_d      = clr_x;
      y_d      = clr_y;
      colour_d = clr_col;
      cx_d     = clr_x;
      cy_d     = clr_y;
    end
    if ((state_q == S_CLEAR) && last_px) begin
      done_d = 1'b1;
      cx_d   = 8'd0;
      cy_d   = 7'd0;
    end
    if (arb_en && gnt_valid) begin
      ack_d    = 3'b001 << gnt_idx;
      x_d      = sel_x;
      y_d      = sel_y;
      colour_d = sel_col;
      plot_d   = (sel_x <= X_MAX) && (sel_y <= Y_MAX);
      ptr_d    = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd0;
      cx_q       <= 8'd0;
      cy_q       <= 7'd0;
      ack_q      <= 3'd0;
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'd0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      ack_q      <= ack_d;
      x          <= x_d;
      y          <= y_d;
      colour     <= colour_d;
      plot       <= plot_d;
      busy       <= busy_d;
      clear_done <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Directed bench for vga_plot_scheduler: reset, lone requester, round-robin, out-of-range, clear, mid-clear reset.
module tb_vga_plot_scheduler;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear_start = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, clear_done, state_dbg;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_plot_scheduler_if bus ();

  vga_plot_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear_start(clear_start),
    .rq         (bus),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .clear_done (clear_done),
    .state_dbg  (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    bus.req_x[i*8 +: 8]   = px;
    bus.req_y[i*7 +: 7]   = py;
    bus.req_col[i*3 +: 3] = pc;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int ord[4];
    int nbusy;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ecol;
    logic [14:0] last_xy;

    bus.req = 3'd0; bus.req_x = '0; bus.req_y = '0; bus.req_col = '0;
    ord = '{0, 1, 2, 0};

    // Reset state
    tick();
    chk("rst_outs", {bus.ack, x, y, colour, plot, busy, clear_done}, 0);
    chk("rst_state", state_dbg, 0);
    resetn = 1'b1;
    tick();

    // Basic grant from req0
    set_req(0, 8'd5, 7'd7, 3'd1);
    bus.req = 3'b001;
    tick();
    chk("t1_ack", bus.ack, 3'b001);
    chk("t1_pix", {plot, x, y, colour}, {1'b1, 8'd5, 7'd7, 3'd1});
    bus.req = 3'b000;
    tick();
    chk("t1_idle", {bus.ack, plot}, 0);

    // Lone requester 1: grant every second cycle, three pixels
    set_req(1, 8'd10, 7'd20, 3'd2);
    bus.req = 3'b010;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk("t2_ack", bus.ack, 3'b010);
        chk("t2_pix", {plot, x, y, colour},
            {1'b1, 8'(10 + k / 2), 7'(20 + k / 2), 3'(2 + k / 2)});
        set_req(1, 8'(11 + k / 2), 7'(21 + k / 2), 3'(3 + k / 2));
      end else begin
        chk("t2_gap", {bus.ack, plot}, 0);
      end
      if (k == 5) bus.req = 3'b000;
    end
    tick();
    chk("t2_after", bus.ack, 0);

    // One req2 grant brings the pointer round to 0
    set_req(2, 8'd30, 7'd31, 3'd3);
    bus.req = 3'b100;
    tick();
    chk("t3_pre", {bus.ack, x}, {3'b100, 8'd30});
    bus.req = 3'b000;
    tick();

    // Round-robin with all three held
    set_req(0, 8'd40, 7'd1, 3'd4);
    set_req(1, 8'd41, 7'd2, 3'd5);
    set_req(2, 8'd42, 7'd3, 3'd6);
    bus.req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("t3_ack", bus.ack, 3'b001 << ord[g]);
      chk("t3_pix", {plot, x, y, colour},
          {1'b1, 8'(40 + ord[g]), 7'(1 + ord[g]), 3'(4 + ord[g])});
      if (g == 3) bus.req = 3'b000;
    end
    tick();

    // Out of range then last valid pixel
    set_req(0, 8'd160, 7'd10, 3'd2);
    bus.req = 3'b001;
    tick();
    chk("t5_oor_ack", bus.ack, 3'b001);
    chk("t5_oor_pix", {plot, x, y}, {1'b0, 8'd160, 7'd10});
    bus.req = 3'b000;
    tick();
    set_req(0, 8'd159, 7'd119, 3'd3);
    bus.req = 3'b001;
    tick();
    chk("t5_edge", {bus.ack, plot, x, y}, {3'b001, 1'b1, 8'd159, 7'd119});
    bus.req = 3'b000;
    tick();

    // Full-screen clear; req2 arrives with clear_start and waits
    set_req(2, 8'd3, 7'd4, 3'd5);
    bus.req = 3'b100;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("t4_start", {busy, plot, bus.ack, x, y}, {1'b1, 1'b1, 3'b000, 8'd0, 7'd0});
    ex = 8'd0; ey = 7'd0; nbusy = 0; last_xy = '0;
    for (int n = 0; n < 19300 && busy; n++) begin
`ifdef PLOT_SCHED_BORDER_EN
      ecol = (ex == 8'd0 || ex == 8'd159 || ey == 7'd0 || ey == 7'd119) ? 3'd7 : 3'd0;
`else
      ecol = 3'd0;
`endif
      chk("t4_xy", {x, y}, {ex, ey});
      chk("t4_col_plot_ack", {colour, plot, bus.ack}, {ecol, 1'b1, 3'b000});
      last_xy = {x, y};
      nbusy++;
      if (ex == 8'd159) begin
        ex = 8'd0;
        ey = ey + 7'd1;
      end else begin
        ex = ex + 8'd1;
      end
      tick();
    end
    chk("t4_len", nbusy, 19200);
    chk("t4_last", last_xy, {8'd159, 7'd119});
    chk("t4_done", {busy, clear_done}, {1'b0, 1'b1});
    chk("t4_req2", {bus.ack, plot, x, y, colour}, {3'b100, 1'b1, 8'd3, 7'd4, 3'd5});
    bus.req = 3'b000;
    tick();
    chk("t4_done_pulse", {clear_done, bus.ack}, 0);

    // Reset in the middle of a clear
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (100) tick();
    chk("t1_midclr_busy", {busy, plot}, {1'b1, 1'b1});
    #2 resetn = 1'b0;
    #1;
    chk("t1_async_rst", {bus.ack, x, y, colour, plot, busy, clear_done, state_dbg}, 0);
    tick();
    resetn = 1'b1;
    repeat (3) begin
      tick();
      chk("t1_no_done", {busy, clear_done, plot}, 0);
    end
    set_req(0, 8'd5, 7'd7, 3'd1);
    bus.req = 3'b001;
    tick();
    chk("t1_post_rst", {bus.ack, plot, x, y, colour}, {3'b001, 1'b1, 8'd5, 7'd7, 3'd1});
    bus.req = 3'b000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
